// File: rtl/cpu_run_controller_if.sv
// Harness/core bundle for the CPU run controller.
// master: debug harness + core side; slave: the controller.
interface cpu_run_controller_if #(
  parameter int PC_W  = 4,
  parameter int CNT_W = 16
);
  logic             start;
  logic             stop;
  logic             step;
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;
  logic [CNT_W-1:0] cycle_limit;
  logic             halt_on_zero;
  logic [PC_W-1:0]  pc_in;
  logic             zero_flag_in;
  logic             cpu_en;
  logic             pipe_flush;
  logic             busy;
  logic             halted;
  logic [2:0]       halt_cause;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output start, stop, step, bp_en, bp_addr,
    output cycle_limit, halt_on_zero,
    output pc_in, zero_flag_in,
    input  cpu_en, pipe_flush, busy, halted,
    input  halt_cause, cycle_count
  );

  modport slave (
    input  start, stop, step, bp_en, bp_addr,
    input  cycle_limit, halt_on_zero,
    input  pc_in, zero_flag_in,
    output cpu_en, pipe_flush, busy, halted,
    output halt_cause, cycle_count
  );
endinterface

// File: rtl/cpu_run_controller.sv
// Run controller: gates CPU clock-enable for start/stop/step,
// breakpoint, cycle budget and halt-on-zero. Ports: clk, rst_n, bus.
module cpu_run_controller #(
  parameter int PC_W         = 4,
  parameter int CNT_W        = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input logic clk,
  input logic rst_n,
  cpu_run_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_RUN, S_STEP, S_HALT
  } state_t;

  localparam int FW =
    (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLUSH_LAST =
    FW'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [2:0] C_NONE  = 3'd0;
  localparam logic [2:0] C_STOP  = 3'd1;
  localparam logic [2:0] C_BP    = 3'd2;
  localparam logic [2:0] C_LIMIT = 3'd3;
  localparam logic [2:0] C_ZERO  = 3'd4;
  localparam logic [2:0] C_STEP  = 3'd5;

  state_t           state_q, state_d;
  logic [FW-1:0]    flush_q, flush_d;
  logic [CNT_W-1:0] count_q;
  logic [2:0]       cause_q, cause_d;
  logic             resumed_q, resumed_d;
  logic             cold;
  logic             bp_hit, lim_hit, zero_hit;
  logic             hit_any;
  logic             en;

  // Breakpoint is masked on the first RUN cycle after a
  // resume so the core can step off the PC it halted on.
  always_comb begin
    bp_hit   = bus.bp_en && (bus.pc_in == bus.bp_addr)
               && !resumed_q;
    lim_hit  = (bus.cycle_limit != '0)
               && (count_q >= bus.cycle_limit);
    zero_hit = bus.halt_on_zero && bus.zero_flag_in;
    hit_any  = bus.stop || bp_hit || lim_hit || zero_hit;
    en       = ((state_q == S_RUN) && !hit_any)
               || (state_q == S_STEP);
  end

  always_comb begin
    state_d   = state_q;
    flush_d   = flush_q;
    cause_d   = cause_q;
    resumed_d = 1'b0;
    cold      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FLUSH;
          flush_d = '0;
          cause_d = C_NONE;
          cold    = 1'b1;
        end else if (bus.step) begin
          state_d = S_STEP;
        end
      end
      S_FLUSH: begin
        if (bus.stop) begin
          state_d = S_HALT;
          cause_d = C_STOP;
          flush_d = '0;
        end else if (flush_q == FLUSH_LAST) begin
          state_d = S_RUN;
          flush_d = '0;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
      S_RUN: begin
        if (hit_any) begin
          state_d = S_HALT;
          if (bus.stop)     cause_d = C_STOP;
          else if (bp_hit)  cause_d = C_BP;
          else if (lim_hit) cause_d = C_LIMIT;
          else              cause_d = C_ZERO;
        end
      end
      S_STEP: begin
        state_d = S_HALT;
        cause_d = C_STEP;
      end
      S_HALT: begin
        if (bus.start) begin
          state_d   = S_RUN;
          resumed_d = 1'b1;
        end else if (bus.step) begin
          state_d = S_STEP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      flush_q   <= '0;
      cause_q   <= C_NONE;
      resumed_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      flush_q   <= flush_d;
      cause_q   <= cause_d;
      resumed_q <= resumed_d;
      if (cold)
        count_q <= '0;
      else if (en && (count_q != CNT_MAX))
        count_q <= count_q + 1'b1;
    end
  end

  assign bus.cpu_en      = en;
  assign bus.pipe_flush  = (state_q == S_FLUSH);
  assign bus.busy        = (state_q == S_FLUSH)
                           || (state_q == S_RUN)
                           || (state_q == S_STEP);
  assign bus.halted      = (state_q == S_HALT);
  assign bus.halt_cause  = cause_q;
  assign bus.cycle_count = count_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Scoreboard bench for cpu_run_controller (CNT_W=4).
// Stimulus queues expected per-cycle outputs; monitor compares.
module tb_cpu_run_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] pc;

  cpu_run_controller_if #(.PC_W(4), .CNT_W(4)) bus();

  cpu_run_controller #(
    .PC_W(4), .CNT_W(4), .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Minimal core model: PC counts while enabled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              pc <= '0;
    else if (bus.pipe_flush) pc <= '0;
    else if (bus.cpu_en)     pc <= pc + 1'b1;
  end

  assign bus.pc_in = pc;

  typedef struct {
    int         cyc;
    string      nm;
    logic       en, fl, bs, hl;
    logic [2:0] ca;
    logic [3:0] cnt;
    int         pcv;
  } exp_t;

  exp_t q[$];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic exp(string nm, bit en, bit fl, bit bs,
                     bit hl, int ca, int cnt, int pcv);
    exp_t e;
    e.cyc = cyc; e.nm = nm;
    e.en = en; e.fl = fl; e.bs = bs; e.hl = hl;
    e.ca = 3'(ca); e.cnt = 4'(cnt); e.pcv = pcv;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      bit   bad;
      e = q.pop_front();
      checks <= checks + 1;
      bad = (e.cyc != cyc)
         || (bus.cpu_en != e.en) || (bus.pipe_flush != e.fl)
         || (bus.busy != e.bs) || (bus.halted != e.hl)
         || (bus.halt_cause != e.ca)
         || (bus.cycle_count != e.cnt)
         || (e.pcv >= 0 && int'(pc) != e.pcv);
      if (bad) begin
        errors <= errors + 1;
        $display("FAIL %s cyc %0d got en=%b fl=%b busy=%b hlt=%b cause=%0d cnt=%0d pc=%0d exp en=%b fl=%b busy=%b hlt=%b cause=%0d cnt=%0d pc=%0d",
          e.nm, cyc, bus.cpu_en, bus.pipe_flush, bus.busy,
          bus.halted, bus.halt_cause, bus.cycle_count, pc,
          e.en, e.fl, e.bs, e.hl, e.ca, e.cnt, e.pcv);
      end
    end
  end

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    bus.start = 0; bus.stop = 0; bus.step = 0;
    bus.bp_en = 0; bus.bp_addr = '0;
    bus.cycle_limit = '0; bus.halt_on_zero = 0;
    bus.zero_flag_in = 0;
    exp("rst_async", 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    exp("rst_rel", 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.start = 0; bus.stop = 0; bus.step = 0;
    bus.bp_en = 0; bus.bp_addr = '0;
    bus.cycle_limit = '0; bus.halt_on_zero = 0;
    bus.zero_flag_in = 0;

    // Cycle budget of 10 after cold start
    do_reset();
    tick(); bus.start = 1; bus.cycle_limit = 4'd10;
    exp("t1_idle", 0, 0, 0, 0, 0, 0, 0);
    tick(); bus.start = 0;
    exp("t1_flush0", 0, 1, 1, 0, 0, 0, 0);
    tick();
    exp("t1_flush1", 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      exp("t1_run", 1, 0, 1, 0, 0, i, i);
    end
    tick();
    exp("t1_limdet", 0, 0, 1, 0, 0, 10, 10);
    tick();
    exp("t1_halt", 0, 0, 0, 1, 3, 10, 10);

    // Breakpoint at PC 5, resume past it, then stop
    do_reset();
    tick(); bus.start = 1; bus.bp_en = 1; bus.bp_addr = 4'd5;
    exp("t2_idle", 0, 0, 0, 0, 0, 0, 0);
    tick(); bus.start = 0;
    exp("t2_flush0", 0, 1, 1, 0, 0, 0, 0);
    tick();
    exp("t2_flush1", 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      exp("t2_run", 1, 0, 1, 0, 0, i, i);
    end
    tick();
    exp("t2_bpdet", 0, 0, 1, 0, 0, 5, 5);
    tick(); bus.start = 1;
    exp("t2_bphalt", 0, 0, 0, 1, 2, 5, 5);
    tick(); bus.start = 0;
    exp("t2_resume", 1, 0, 1, 0, 2, 5, 5);
    tick();
    exp("t2_past", 1, 0, 1, 0, 2, 6, 6);
    tick(); bus.stop = 1;
    exp("t2_stopdet", 0, 0, 1, 0, 2, 7, 7);

    // Three single steps from HALT
    for (int k = 0; k < 3; k++) begin
      tick(); bus.stop = 0; bus.step = 1;
      exp("t3_halt", 0, 0, 0, 1, (k == 0) ? 1 : 5,
          7 + k, 7 + k);
      tick(); bus.step = 0;
      exp("t3_step", 1, 0, 1, 0, (k == 0) ? 1 : 5,
          7 + k, 7 + k);
    end

    // Halt on zero flag, then stop wins over zero
    tick(); bus.start = 1; bus.halt_on_zero = 1;
    bus.bp_en = 0;
    exp("t3_final", 0, 0, 0, 1, 5, 10, 10);
    tick(); bus.start = 0;
    exp("t4_run", 1, 0, 1, 0, 5, 10, 10);
    tick(); bus.zero_flag_in = 1;
    exp("t4_zdet", 0, 0, 1, 0, 5, 11, 11);
    tick(); bus.start = 1;
    exp("t4_zhalt", 0, 0, 0, 1, 4, 11, 11);
    tick(); bus.start = 0; bus.stop = 1;
    exp("t4_prio", 0, 0, 1, 0, 4, 11, 11);
    tick(); bus.stop = 0; bus.zero_flag_in = 0;
    bus.halt_on_zero = 0;
    exp("t4_stophalt", 0, 0, 0, 1, 1, 11, 11);

    // Async reset mid-run with count at 7
    do_reset();
    tick(); bus.start = 1;
    exp("t5_idle", 0, 0, 0, 0, 0, 0, 0);
    tick(); bus.start = 0;
    exp("t5_flush0", 0, 1, 1, 0, 0, 0, 0);
    tick();
    exp("t5_flush1", 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      tick();
      exp("t5_run", 1, 0, 1, 0, 0, i, i);
    end
    tick(); rst_n = 1'b0;
    exp("t5_async", 0, 0, 0, 0, 0, 0, 0);
    tick(); rst_n = 1'b1;
    exp("t5_rel", 0, 0, 0, 0, 0, 0, 0);
    tick();
    exp("t5_idle2", 0, 0, 0, 0, 0, 0, 0);

    // Counter saturation at 15, start ignored in RUN
    do_reset();
    tick(); bus.start = 1;
    exp("t6_idle", 0, 0, 0, 0, 0, 0, 0);
    tick(); bus.start = 0;
    exp("t6_flush0", 0, 1, 1, 0, 0, 0, 0);
    tick();
    exp("t6_flush1", 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      bus.start = (i == 10);
      exp("t6_run", 1, 0, 1, 0, 0, (i > 15) ? 15 : i, -1);
    end
    tick(); bus.start = 0; bus.stop = 1;
    exp("t6_stopdet", 0, 0, 1, 0, 0, 15, -1);
    tick(); bus.stop = 0;
    exp("t6_halt", 0, 0, 0, 1, 1, 15, -1);

    for (int w = 0; w < 10 && q.size() > 0; w++) tick();
    if (q.size() > 0) begin
      $display("FAIL drain got %0d pending required 0",
               q.size());
      errors = errors + 1;
    end
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Sequences execution of the 8-bit pipelined CPU by gating its clock-enable.
- Supports start, stop, single-step, a PC breakpoint, a cycle budget and halt-on-zero-flag.
- Flushes the pipeline before a cold start and counts executed cycles.
- Sits between the debug/test harness and the CPU core. It observes the core's PC and zero flag and drives the core's enable and flush inputs.

Parameters:
PC_W, 4, width of CPU program counter
CNT_W, 16, width of executed-cycle counter and cycle budget
FLUSH_CYCLES, 2, cycles pipe_flush is held on cold start (pipeline depth minus 1); must be >=1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: cold start from IDLE, resume from HALT
stop  in  1  pulse/level: manual halt request
step  in  1  pulse: execute exactly one enabled cycle from IDLE or HALT
bp_en  in  1  breakpoint enable
bp_addr  in  PC_W  breakpoint PC
cycle_limit  in  CNT_W  cycle budget; 0 = unlimited
halt_on_zero  in  1  halt when CPU zero flag set
pc_in  in  PC_W  CPU current PC (pc_out of core)
zero_flag_in  in  1  CPU zero flag
cpu_en  out  1  clock-enable to CPU pipeline (combinational)
pipe_flush  out  1  synchronous flush to CPU pipeline registers
busy  out  1  high in FLUSH, RUN, STEP
halted  out  1  high in HALT
halt_cause  out  3  0 none, 1 stop, 2 breakpoint, 3 limit, 4 zero, 5 step
cycle_count  out  CNT_W  enabled cycles since last cold start

Behaviour:
- Reset (async, rst_n=0): state=IDLE; cpu_en=0, pipe_flush=0, busy=0, halted=0, halt_cause=0, cycle_count=0, flush counter=0. Reset mid-run aborts immediately with no drain.
- States: IDLE, FLUSH, RUN, STEP, HALT.
- IDLE:
  - start -> FLUSH; cycle_count and halt_cause cleared on that edge.
  - Else step -> STEP; start has priority over step.
  - stop is ignored.
- FLUSH:
  - pipe_flush=1 and cpu_en=0 for exactly FLUSH_CYCLES cycles, then -> RUN.
  - stop during FLUSH -> HALT, cause 1.
- RUN:
  - halt_req is combinational, priority stop > breakpoint > limit > zero:
    - stop;
    - bp_en && pc_in==bp_addr, except on the first RUN cycle after a resume from HALT;
    - cycle_limit!=0 && cycle_count>=cycle_limit;
    - halt_on_zero && zero_flag_in.
  - cpu_en = (state==RUN) && !halt_req. The CPU never advances in the cycle a halt is detected, so the PC stays frozen at bp_addr on a breakpoint.
  - On halt_req -> HALT next edge; halt_cause latched with the highest-priority cause.
  - start and step are ignored in RUN.
- STEP:
  - cpu_en=1 for exactly one cycle. Breakpoint, limit and zero are ignored; stop is ignored.
  - Then -> HALT, cause 5.
- HALT:
  - halted=1; halt_cause held.
  - start -> RUN (resume, no flush, cycle_count kept).
  - step -> STEP; start has priority over step.
- cycle_count: increments on each edge where cpu_en=1; saturates at 2^CNT_W-1, no wrap.
- With cycle_limit=N!=0, exactly N enabled cycles occur after a cold start. A resume with cycle_count>=N halts again with zero enabled cycles, cause 3.
- Changing cycle_limit, bp_addr or bp_en takes effect the same cycle (combinational compare).

Test Plan:
- Reset, start, cycle_limit=10, bp_en=0 -> pipe_flush high exactly 2 cycles, then 10 cycles with cpu_en=1, halted=1, halt_cause=3, cycle_count=10.
- bp_en=1, bp_addr=5, program counts PC 0..15, start -> cpu_en low in the cycle pc_in==5, halt_cause=2. Then start -> PC advances past 5 with no immediate re-halt.
- From HALT, three step pulses -> three single-cycle cpu_en pulses, cycle_count +3, halt_cause=5 each time, PC advances by 3.
- halt_on_zero=1, core produces zero result -> cpu_en drops the same cycle zero_flag_in=1, halt_cause=4. Same cycle with stop=1 -> halt_cause=1 (priority).
- rst_n pulled low mid-RUN (cycle_count=7) -> all outputs 0 asynchronously before the next edge; state IDLE after release.
- Cycle-count saturation: CNT_W=4, cycle_limit=0, run 20 cycles -> cycle_count sticks at 15; start during RUN is ignored.
